// File: rtl/somador_bcd_3_reg.sv
// Registered 3-digit BCD adder: {cout,sum} = a + b + cin, one clock of latency.
// Optional input-digit checking on bcd_err is built when BCD_CHECK_EN is defined.
module somador_bcd_3_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] sum,
  output logic        cout,
  output logic        out_valid,
  output logic        bcd_err
);

  // One decimal digit cell: returns {carry_out, digit}. Non-BCD inputs follow
  // the same rule, so the result stays deterministic.
  function automatic logic [4:0] bcd_cell(input logic [3:0] x,
                                          input logic [3:0] y,
                                          input logic       c);
    logic [4:0] t;
    logic [4:0] adj;
    t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    adj = t + 5'd6;
    if (t > 5'd9) begin
      bcd_cell = {1'b1, adj[3:0]};
    end else begin
      bcd_cell = {1'b0, t[3:0]};
    end
  endfunction

  // True when a 4-bit digit is outside 0..9.
  function automatic logic digit_bad(input logic [3:0] d);
    digit_bad = (d > 4'd9);
  endfunction

  logic [4:0]  cell0_s;
  logic [4:0]  cell1_s;
  logic [4:0]  cell2_s;
  logic [11:0] sum_d;
  logic        cout_d;
  logic [11:0] sum_q;
  logic        cout_q;
  logic        out_valid_q;

  // Ripple-carry chain through the three digit cells.
  always_comb begin
    cell0_s = bcd_cell(a[3:0],  b[3:0],  cin);
    cell1_s = bcd_cell(a[7:4],  b[7:4],  cell0_s[4]);
    cell2_s = bcd_cell(a[11:8], b[11:8], cell1_s[4]);
    sum_d   = {cell2_s[3:0], cell1_s[3:0], cell0_s[3:0]};
    cout_d  = cell2_s[4];
  end

  // Output register: capture on in_valid, hold otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= 12'h000;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= 1'b1;
    end else begin
      sum_q       <= sum_q;
      cout_q      <= cout_q;
      out_valid_q <= 1'b0;
    end
  end

`ifdef BCD_CHECK_EN
  logic bcd_err_d;
  logic bcd_err_q;

  // OR of the per-digit range checks over both operands.
  always_comb begin
    bcd_err_d = digit_bad(a[3:0]) | digit_bad(a[7:4]) | digit_bad(a[11:8]) |
                digit_bad(b[3:0]) | digit_bad(b[7:4]) | digit_bad(b[11:8]);
  end

  // Error flag follows the same capture/hold rule as the sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_err_q <= 1'b0;
    end else if (in_valid) begin
      bcd_err_q <= bcd_err_d;
    end else begin
      bcd_err_q <= bcd_err_q;
    end
  end

  assign bcd_err = bcd_err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_somador_bcd_3_reg.sv
// Self-checking bench for somador_bcd_3_reg: directed vector table, hand-written
// reset/hold/back-to-back sequences, and random operands against an integer model.
module tb_somador_bcd_3_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] a;
  logic [11:0] b;
  logic        cin;
  logic [11:0] sum;
  logic        cout;
  logic        out_valid;
  logic        bcd_err;

  int checks;
  int failures;

  somador_bcd_3_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .bcd_err   (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic [11:0] sum;
    logic        cout;
    logic        bad;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic bad);
`ifdef BCD_CHECK_EN
    return bad;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one valid capture (called at a negedge) and check it at the next negedge.
  task automatic apply_check(input string name, input logic [11:0] va, input logic [11:0] vb,
                             input logic vc, input logic [11:0] es, input logic ec,
                             input logic ebad);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, ".sum"},       32'(sum),       32'(es));
    check({name, ".cout"},      32'(cout),      32'(ec));
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".bcd_err"},   32'(bcd_err),   32'(exp_err(ebad)));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{"zero",      12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{"9p1",       12'h009, 12'h001, 1'b0, 12'h010, 1'b0, 1'b0};
    vecs[2]  = '{"15p27",     12'h015, 12'h027, 1'b0, 12'h042, 1'b0, 1'b0};
    vecs[3]  = '{"99p1",      12'h099, 12'h001, 1'b0, 12'h100, 1'b0, 1'b0};
    vecs[4]  = '{"349p651",   12'h349, 12'h651, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[5]  = '{"500p500",   12'h500, 12'h500, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[6]  = '{"999p1",     12'h999, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[7]  = '{"999p0c1",   12'h999, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[8]  = '{"999p999c1", 12'h999, 12'h999, 1'b1, 12'h999, 1'b1, 1'b0};
    vecs[9]  = '{"9p0",       12'h009, 12'h000, 1'b0, 12'h009, 1'b0, 1'b0};
    vecs[10] = '{"badA",      12'h00A, 12'h000, 1'b0, 12'h010, 1'b0, 1'b1};
    vecs[11] = '{"FpFc1",     12'h00F, 12'h00F, 1'b1, 12'h015, 1'b0, 1'b1};

    // Reset held for two edges while valid, large operands present.
    rst_n = 1'b0; in_valid = 1'b1; a = 12'h999; b = 12'h999; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.sum",       32'(sum),       32'h000);
    check("rst.cout",      32'(cout),      32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.bcd_err",   32'(bcd_err),   32'd0);
    rst_n = 1'b1;

    // Directed table, applied back-to-back.
    for (int i = 0; i < 12; i++) begin
      apply_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout, vecs[i].bad);
    end

    // Hold: capture 15+27, then present 500+500 with in_valid low for two cycles.
    apply_check("hold.cap", 12'h015, 12'h027, 1'b0, 12'h042, 1'b0, 1'b0);
    in_valid = 1'b0; a = 12'h500; b = 12'h500; cin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold.sum",       32'(sum),       32'h042);
      check("hold.cout",      32'(cout),      32'd0);
      check("hold.out_valid", 32'(out_valid), 32'd0);
    end

    // Error flag holds through an idle cycle after an invalid-digit capture.
    apply_check("errhold.cap", 12'hA00, 12'h000, 1'b0, 12'h000, 1'b1, 1'b1);
    in_valid = 1'b0; a = 12'h000; b = 12'h000;
    @(posedge clk);
    @(negedge clk);
    check("errhold.bcd_err", 32'(bcd_err), 32'(exp_err(1'b1)));
    check("errhold.cout",    32'(cout),    32'd1);

    // Back-to-back, then a reset pulse with valid high clears everything.
    apply_check("b2b.0", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);
    apply_check("b2b.1", 12'h555, 12'h445, 1'b1, 12'h001, 1'b1, 1'b0);
    apply_check("b2b.2", 12'h088, 12'h012, 1'b0, 12'h100, 1'b0, 1'b0);
    rst_n = 1'b0; a = 12'h999; b = 12'h999; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2.sum",       32'(sum),       32'h000);
    check("rst2.out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Random valid operands against an integer model.
    for (int r = 0; r < 30; r++) begin
      int ia, ib, ic, tot;
      ia  = int'($urandom_range(999, 0));
      ib  = int'($urandom_range(999, 0));
      ic  = int'($urandom_range(1, 0));
      tot = ia + ib + ic;
      apply_check("rand", to_bcd(ia), to_bcd(ib), 1'(ic),
                  to_bcd(tot % 1000), (tot >= 1000), 1'b0);
    end

    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("final.out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/somador_bcd_3_reg.md
Name: somador_bcd_3_reg

Overview:
- Registered 3-digit BCD adder: sum = A + B + cin, with hundreds, tens and units digits and a decimal carry-out.
- Ripple of three single-digit BCD adder cells (binary add, plus a +6 correction when the result exceeds 9), followed by an output register stage.
- Sits in the datapath of the decimal arithmetic unit; its output matches the combinational behavioural, dataflow and structural 3-digit adders, delayed by one clock.

Parameters:
- None. Width is fixed at 3 digits, 12-bit BCD.

Ports:
- clk       input   1   rising-edge clock
- rst_n     input   1   synchronous reset, active-low
- in_valid  input   1   operands valid this cycle; capture enable
- a         input   12  operand A, BCD {hundreds[11:8], tens[7:4], units[3:0]}
- b         input   12  operand B, same packing
- cin       input   1   decimal carry-in
- sum       output  12  registered BCD sum, same packing
- cout      output  1   registered decimal carry-out (result ≥ 1000)
- out_valid output  1   sum/cout updated from a valid capture
- bcd_err   output  1   registered flag: some input digit exceeded 9 (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: sum=12'h000, cout=0, out_valid=0, bcd_err=0. Reset has priority over in_valid on the same edge.
- Latency: 1 cycle. Operands sampled at edge N with in_valid=1 appear on sum/cout at edge N, and out_valid=1 for that cycle.
- When in_valid=0 at an edge:
  - sum, cout and bcd_err hold their previous values.
  - out_valid=0.
- Digit cell, for digits i = 0 (units), 1 (tens), 2 (hundreds):
  - t = a_i + b_i + c_i, computed 5 bits wide, with c_0 = cin.
  - If t > 9: digit = (t + 6)[3:0] and c_{i+1} = 1.
  - Else: digit = t[3:0] and c_{i+1} = 0.
- cout = c_3. Range of a valid result: 0..1999, i.e. cout:sum.
- Wrap-around: results ≥ 1000 leave sum = result − 1000 with cout=1.
  - Example: 999 + 1 → sum=000, cout=1.
- Invalid digits (>9) are not rejected. The same cell rule applies, which gives deterministic output.
  - Example: digit F + F + 1 → t = 31 → digit 5, carry 1.
- The combinational path is purely a function of a, b and cin. There is no state other than the output registers.
- Back-to-back in_valid: a new result every cycle with no bubbles.

Optional Feature:
- Macro BCD_CHECK_EN.
- Defined: on a valid capture, bcd_err is registered as the OR over all six input digits of (digit > 9). It updates only when in_valid=1 and resets to 0.
- Undefined: bcd_err is constant 0; no check logic is built. Sum and cout behaviour are identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles while in_valid=1 with a=999, b=999 → sum=000, cout=0, out_valid=0, bcd_err=0.
- Basic and carry chain, one cycle after each capture:
  - 0+0 → 000/0
  - 9+1 → 010/0
  - 15+27 → 042/0
  - 99+1 → 100/0
- Overflow:
  - 349+651 → 000/1
  - 500+500 → 000/1
  - 999+1 → 000/1
  - 999+0 with cin=1 → 000/1
  - 999+999 with cin=1 → 999/1
- Hold and handshake: capture 15+27, then drop in_valid and apply 500+500 → sum stays 042, out_valid=0.
- Back-to-back valid captures → each result appears exactly one cycle later.
- Invalid digit: a=12'h00A, b=0, in_valid=1 → with BCD_CHECK_EN, bcd_err=1 and sum=010, cout=0. Without the macro, bcd_err=0 and sum is the same.
- Random: 20+ random valid operands 0..999 with random cin → {cout,sum} equals (A+B+cin) in decimal, checked against an integer model.
